pwr_event_accum: RTL and testbench
==================================

Name: pwr_event_accum

Overview:
- Synthesizable power-event accumulator downstream of the weighted gate library.
- Takes one output line per gate group and detects 0->1 transitions, the power-consuming event.
- Each detected transition adds a per-channel weight over a programmable cycle window.
- After the window, dumps the per-channel totals through a valid/ready stream to the testbench or an on-chip monitor.

Parameters:
- N_CH, 4: number of monitored gate-output channels (1..7).
- W_WGT, 4: bit width of each per-channel weight.
- W_CNT, 16: accumulator width per channel.
- W_WIN, 8: window-length width.
- W_CH, 3: channel index width; must satisfy 2^W_CH > N_CH.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a measurement window.
- win_len  in  W_WIN  window length in cycles; sampled on accepted start.
- evt  in  N_CH  monitored gate outputs, level signals, synchronous to clk.
- weights  in  N_CH*W_WGT  per-channel weights; channel i at bits [i*W_WGT +: W_WGT]; static during a window.
- busy  out  1  high in ACCUM and DUMP.
- out_valid  out  1  dump beat valid.
- out_ready  in  1  consumer accepts beat.
- out_ch  out  W_CH  channel index of current beat.
- out_data  out  W_CNT  accumulated total of current beat.
- ovf  out  N_CH  sticky per-channel saturation flags.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset.
- Reset values: state IDLE; busy, out_valid, out_ch, out_data, ovf, all accumulators, window counter and evt_d all 0.
- Edge detection:
  - evt_d <= evt every cycle in all states.
  - rise = evt & ~evt_d.
  - A level already high when the window opens does not count unless it was low the previous cycle.
- States are IDLE, ACCUM and DUMP.
- IDLE:
  - start=1 with win_len!=0: clear all accumulators and ovf, load window counter with win_len, go to ACCUM next cycle.
  - start=1 with win_len=0: ignored, remain IDLE.
  - Accumulators hold their last values in IDLE.
- ACCUM:
  - Each cycle, for each channel i with rise[i]=1: acc[i] <= acc[i] + weight[i].
  - Addition is unsigned and zero-extended.
  - If the sum exceeds 2^W_CNT-1, acc[i] saturates at all-ones and ovf[i] sets.
  - Window counter decrements each cycle; the cycle where it reaches 0 (after exactly win_len ACCUM cycles) is the last sampled cycle.
  - Next state is DUMP.
  - Latency: start accepted at cycle t; rises sampled in cycles t+1 .. t+win_len; first out_valid at t+win_len+1.
- DUMP:
  - Beats go out in channel order 0..N_CH-1, with out_data = acc[out_ch].
  - out_valid stays high and out_ch/out_data stay stable until out_valid & out_ready.
  - out_ready=1 continuously gives one beat per cycle.
  - On acceptance of the last beat: out_valid=0 the next cycle, state IDLE.
  - out_ch returns to 0.
- start while busy=1: ignored, with no restart and no clearing.
- weights change mid-window: new value is used from the next cycle; no error.
- reset mid-window or mid-dump: immediate return to reset values next cycle; partial results are discarded.
- ovf stays asserted until the next accepted start or reset.

Optional Feature:
- Macro: PWR_EVENT_TOTAL_EN.
- Defined: DUMP emits one extra final beat with out_ch=N_CH and out_data = saturating sum of all channel accumulators. ovf is unaffected by saturation of this total. The IDLE transition follows acceptance of this total beat.
- Undefined: exactly N_CH beats; no total logic is synthesized.

Test Plan:
- Basic window: weights={4,3,2,1} (ch3..ch0), win_len=10; each evt[i] toggles 0->1->0 twice inside the window -> beats (0,2),(1,4),(2,6),(3,8); first out_valid exactly 11 cycles after start; ovf=0.
- Pre-high level: evt[0]=1 held before start and through the window, weight 5, win_len=8 -> ch0 total 0; evt[0] dropped and re-raised once inside -> total 5.
- Saturation: W_CNT=16, weight[1]=15; evt[1] toggles every other cycle for win_len=255 (128 rises = 1920) -> no ovf. Re-run with W_CNT=10 -> out_data 1023, ovf[1]=1, other channels unaffected.
- Backpressure: out_ready held low 5 cycles, then toggled 1/0 -> each beat held stable; exactly N_CH beats in order; start pulsed during DUMP -> ignored, busy stays 1.
- Reset mid-ACCUM: reset at cycle 3 of a win_len=20 window -> next cycle busy=0, out_valid=0, acc=0, ovf=0; start with win_len=0 -> stays IDLE.
- With PWR_EVENT_TOTAL_EN: the basic-window stimulus -> fifth beat (4,20), then busy=0.

Source files
------------

// File: rtl/pwr_event_accum.sv
// Power-event accumulator: weights 0->1 transitions per channel over a cycle window, then
// streams per-channel totals. Define PWR_EVENT_TOTAL_EN to append a saturating grand-total beat.
module pwr_event_accum #(
  parameter int N_CH  = 4,
  parameter int W_WGT = 4,
  parameter int W_CNT = 16,
  parameter int W_WIN = 8,
  parameter int W_CH  = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [W_WIN-1:0]        win_len,
  input  logic [N_CH-1:0]         evt,
  input  logic [N_CH*W_WGT-1:0]   weights,
  output logic                    busy,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [W_CH-1:0]         out_ch,
  output logic [W_CNT-1:0]        out_data,
  output logic [N_CH-1:0]         ovf
);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DUMP} state_t;

`ifdef PWR_EVENT_TOTAL_EN
  localparam logic [W_CH-1:0] LAST_CH = W_CH'(N_CH);
`else
  localparam logic [W_CH-1:0] LAST_CH = W_CH'(N_CH - 1);
`endif

  state_t            r_state;
  logic              r_busy;
  logic              r_out_valid;
  logic [W_CH-1:0]   r_out_ch;
  logic [N_CH-1:0]   r_ovf;
  logic [N_CH-1:0]   r_evt_d;
  logic [W_WIN-1:0]  r_win;
  logic [W_CNT-1:0]  r_acc [N_CH];

  logic [N_CH-1:0]   w_rise;
  logic [W_CNT:0]    w_sum [N_CH];
  logic [W_CNT-1:0]  w_out_data;

  assign w_rise = evt & ~r_evt_d;

  // One spare MSB per channel catches the carry that signals saturation.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    for (int i = 0; i < N_CH; i++) begin
      w_sum[i] = '0;
      w_sum[i] = {1'b0, r_acc[i]} + {{(W_CNT + 1 - W_WGT){1'b0}}, weights[i*W_WGT +: W_WGT]};
    end
  end

`ifdef PWR_EVENT_TOTAL_EN
  logic [W_CNT+2:0] w_total_raw;
  logic [W_CNT-1:0] w_total;

  always_comb begin
    w_total_raw = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_total_raw = w_total_raw + {3'b000, r_acc[i]};
    end
    w_total = (|w_total_raw[W_CNT+2:W_CNT]) ? '1 : w_total_raw[W_CNT-1:0];
  end
`endif

  // Accumulators are frozen during DUMP, so the beat data is a plain mux of stable registers.
  always_comb begin
    w_out_data = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (r_out_ch == W_CH'(i)) w_out_data = r_acc[i];
    end
`ifdef PWR_EVENT_TOTAL_EN
    if (r_out_ch == W_CH'(N_CH)) w_out_data = w_total;
`endif
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (reset) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_ch    <= '0;
      r_ovf       <= '0;
      r_evt_d     <= '0;
      r_win       <= '0;
      for (int i = 0; i < N_CH; i++) r_acc[i] <= '0;
    end else begin
      r_evt_d <= evt;
      case (r_state)
        S_IDLE: begin
          if (start && (win_len != '0)) begin
            for (int i = 0; i < N_CH; i++) r_acc[i] <= '0;
            r_ovf   <= '0;
            r_win   <= win_len;
            r_busy  <= 1'b1;
            r_state <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          for (int i = 0; i < N_CH; i++) begin
            if (w_rise[i]) begin
              if (w_sum[i][W_CNT]) begin
                r_acc[i] <= '1;
                r_ovf[i] <= 1'b1;
              end else begin
                r_acc[i] <= w_sum[i][W_CNT-1:0];
              end
            end
          end
          r_win <= r_win - W_WIN'(1);
          if (r_win == W_WIN'(1)) begin
            r_state     <= S_DUMP;
            r_out_valid <= 1'b1;
            r_out_ch    <= '0;
          end
        end
        S_DUMP: begin
          if (r_out_valid && out_ready) begin
            if (r_out_ch == LAST_CH) begin
              r_out_valid <= 1'b0;
              r_out_ch    <= '0;
              r_busy      <= 1'b0;
              r_state     <= S_IDLE;
            end else begin
              r_out_ch <= r_out_ch + W_CH'(1);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign out_valid = r_out_valid;
  assign out_ch    = r_out_ch;
  assign out_data  = w_out_data;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_pwr_event_accum.sv
// Directed bench for pwr_event_accum: a default-width instance plus a 10-bit-accumulator
// instance sharing stimulus, so saturation is visible on the narrow one.
module tb_pwr_event_accum;

`ifdef PWR_EVENT_TOTAL_EN
  localparam int N_BEATS = 5;
`else
  localparam int N_BEATS = 4;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  win_len;
  logic [3:0]  evt;
  logic [15:0] weights;
  logic        out_ready;

  logic        busy, out_valid;
  logic [2:0]  out_ch;
  logic [15:0] out_data;
  logic [3:0]  ovf;

  logic        busy_s, out_valid_s;
  logic [2:0]  out_ch_s;
  logic [9:0]  out_data_s;
  logic [3:0]  ovf_s;

  int n_checks = 0;
  int n_errors = 0;

  logic [2:0]  cap_ch     [8];
  logic [15:0] cap_data   [8];
  logic [9:0]  cap_data_s [8];
  int          cap_n;

  always #5 clk = ~clk;

  pwr_event_accum dut (
    .clk(clk), .reset(reset), .start(start), .win_len(win_len), .evt(evt),
    .weights(weights), .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .out_ch(out_ch), .out_data(out_data), .ovf(ovf)
  );

  pwr_event_accum #(.W_CNT(10)) dut_s (
    .clk(clk), .reset(reset), .start(start), .win_len(win_len), .evt(evt),
    .weights(weights), .busy(busy_s), .out_valid(out_valid_s), .out_ready(out_ready),
    .out_ch(out_ch_s), .out_data(out_data_s), .ovf(ovf_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_start(input int len);
    start   = 1'b1;
    win_len = 8'(len);
    tick;
    start   = 1'b0;
  endtask

  // Drains the dump; with bp set, holds ready low 5 cycles then toggles it and pokes start.
  task automatic collect(input bit bp);
    bit          hold;
    logic [2:0]  hold_ch;
    logic [15:0] hold_data;
    hold      = 1'b0;
    hold_ch   = '0;
    hold_data = '0;
    cap_n     = 0;
    for (int i = 0; i < 8; i++) begin
      cap_ch[i] = '1; cap_data[i] = '1; cap_data_s[i] = '1;
    end
    for (int c = 0; c < 60 && cap_n < N_BEATS; c++) begin
      out_ready = bp ? (c >= 5 && (c % 2) == 1) : 1'b1;
      if (bp && c == 2) begin
        start   = 1'b1;
        win_len = 8'd3;
      end
      if (hold) begin
        check("hold_valid", out_valid, 1);
        check("hold_ch", out_ch, hold_ch);
        check("hold_data", out_data, hold_data);
      end
      hold = 1'b0;
      if (out_valid) begin
        if (out_ready) begin
          cap_ch[cap_n]     = out_ch;
          cap_data[cap_n]   = out_data;
          cap_data_s[cap_n] = out_data_s;
          cap_n++;
        end else begin
          hold      = 1'b1;
          hold_ch   = out_ch;
          hold_data = out_data;
        end
      end
      tick;
      if (bp && c == 2) begin
        start = 1'b0;
        check("busy_after_start_in_dump", busy, 1);
      end
    end
    out_ready = 1'b0;
    check("beat_count", cap_n, N_BEATS);
    check("busy_after_dump", busy, 0);
    check("valid_after_dump", out_valid, 0);
    check("ch_after_dump", out_ch, 0);
  endtask

  task automatic check_beats(input logic [15:0] e0, e1, e2, e3);
    logic [15:0] e [4];
    e = '{e0, e1, e2, e3};
    for (int i = 0; i < 4; i++) begin
      check($sformatf("beat%0d_ch", i), cap_ch[i], i);
      check($sformatf("beat%0d_data", i), cap_data[i], e[i]);
    end
`ifdef PWR_EVENT_TOTAL_EN
    check("total_ch", cap_ch[4], 4);
    check("total_data", cap_data[4], e0 + e1 + e2 + e3);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    reset = 1'b1; start = 1'b0; win_len = '0; evt = '0; weights = '0; out_ready = 1'b0;
    @(negedge clk);
    tick; tick;
    check("rst_busy", busy, 0);
    check("rst_valid", out_valid, 0);
    check("rst_ch", out_ch, 0);
    check("rst_data", out_data, 0);
    check("rst_ovf", ovf, 0);
    check("rst_ovf_s", ovf_s, 0);
    reset = 1'b0;
    tick;

    // Basic window: two rises per channel with weights 1..4.
    weights = {4'd4, 4'd3, 4'd2, 4'd1};
    do_start(10);
    check("basic_busy", busy, 1);
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      if (out_valid && lat == 0) lat = k;
      evt = (k == 2 || k == 5) ? 4'hF : 4'h0;
      tick;
    end
    if (out_valid && lat == 0) lat = 11;
    check("basic_latency", lat, 11);
    check("basic_ovf", ovf, 0);
    collect(1'b0);
    check_beats(16'd2, 16'd4, 16'd6, 16'd8);

    // Level already high at window open is not an event.
    weights = {4'd0, 4'd0, 4'd0, 4'd5};
    evt = 4'b0001;
    tick; tick;
    do_start(8);
    for (int k = 1; k <= 8; k++) tick;
    collect(1'b0);
    check_beats(16'd0, 16'd0, 16'd0, 16'd0);
    do_start(8);
    for (int k = 1; k <= 8; k++) begin
      evt = (k == 3) ? 4'b0000 : 4'b0001;
      tick;
    end
    collect(1'b0);
    check_beats(16'd5, 16'd0, 16'd0, 16'd0);
    evt = 4'h0;
    tick;

    // Backpressure with a start pulse during DUMP.
    weights = {4'd4, 4'd3, 4'd2, 4'd1};
    do_start(4);
    for (int k = 1; k <= 4; k++) begin
      evt = (k == 1) ? 4'hF : 4'h0;
      tick;
    end
    collect(1'b1);
    check_beats(16'd1, 16'd2, 16'd3, 16'd4);
    tick;
    check("bp_no_restart", busy, 0);

    // Saturation: 128 rises of weight 15 = 1920; the 10-bit instance clips at 1023.
    weights = 16'h00F0;
    do_start(255);
    for (int k = 1; k <= 255; k++) begin
      evt = {2'b00, k[0], 1'b0};
      tick;
    end
    evt = 4'h0;
    collect(1'b0);
    check_beats(16'd0, 16'd1920, 16'd0, 16'd0);
    check("sat_ovf_wide", ovf, 0);
    check("sat_ch0_narrow", cap_data_s[0], 0);
    check("sat_ch1_narrow", cap_data_s[1], 1023);
    check("sat_ch2_narrow", cap_data_s[2], 0);
    check("sat_ch3_narrow", cap_data_s[3], 0);
    check("sat_ovf_narrow", ovf_s, 4'b0010);
    tick; tick;
    check("sat_ovf_sticky", ovf_s, 4'b0010);

    // Reset in the middle of an accumulation window.
    weights = {4'd4, 4'd3, 4'd2, 4'd1};
    do_start(20);
    check("ovf_cleared_on_start", ovf_s, 0);
    evt = 4'hF;
    tick;
    evt = 4'h0;
    tick;
    check("mid_acc_ch0", out_data, 1);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_valid", out_valid, 0);
    check("rst_mid_data", out_data, 0);
    check("rst_mid_ovf", ovf, 0);
    check("rst_mid_busy_s", busy_s, 0);

    // A zero-length window request is ignored.
    start   = 1'b1;
    win_len = 8'd0;
    tick;
    start   = 1'b0;
    tick;
    check("zero_len_busy", busy, 0);
    tick;
    check("zero_len_valid", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
